// File: rtl/buzzer_alarm_ctrl.sv
// Two-channel buzzer alarm controller: debounced sticky alarms, dwell-based channel
// scheduling and a beep pattern. Optional BUZZER_SILENCE_EN adds a timed silence input.
module buzzer_alarm_ctrl #(
   parameter int DEBOUNCE = 4,
   parameter int BEEP_ON  = 8,
   parameter int BEEP_OFF = 8,
   parameter int DWELL    = 16,
   parameter int CNT_W    = 8
`ifdef BUZZER_SILENCE_EN
   ,
   parameter int SILENCE_CYC = 64
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       above_30_0,
   input  logic       above_25_0,
   input  logic       low_level_0,
   input  logic       above_30_1,
   input  logic       above_25_1,
   input  logic       low_level_1,
   input  logic [1:0] ack,
`ifdef BUZZER_SILENCE_EN
   input  logic       silence,
`endif
   output logic       select,
   output logic       buzz,
   output logic [1:0] alarm
);

   localparam logic [CNT_W-1:0] DB_MAX     = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(BEEP_ON - 1);
   localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(BEEP_OFF - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} beep_state_t;

   logic [1:0]       raw;
   logic [1:0]       alarm_reg, alarm_next;
   logic             select_reg;
   logic [CNT_W-1:0] dwell_reg;
   beep_state_t      state_reg, state_next;
   logic [CNT_W-1:0] phase_reg, phase_next;
   logic             any_alarm;

   assign raw[0] = above_30_0 | ~above_25_0 | low_level_0;
   assign raw[1] = above_30_1 | ~above_25_1 | low_level_1;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic [CNT_W-1:0] db_cnt_reg;
         logic             set_ch;

         always_ff @(posedge clk) begin
            if (!rst_n)
               db_cnt_reg <= '0;
            else if (!raw[gi])
               db_cnt_reg <= '0;
            else if (db_cnt_reg != DB_MAX)
               db_cnt_reg <= db_cnt_reg + 1'b1;
         end

         // Set outranks ack; ack only counts once the raw condition has gone away.
         assign set_ch         = raw[gi] && (db_cnt_reg >= DB_LAST);
         assign alarm_next[gi] = set_ch | (alarm_reg[gi] & ~(ack[gi] & ~raw[gi]));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n)
         alarm_reg <= 2'b00;
      else
         alarm_reg <= alarm_next;
   end

   // Dwell is already 0 whenever alarm was not 11, so entering 11 restarts it for free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         select_reg <= 1'b0;
         dwell_reg  <= '0;
      end else begin
         case (alarm_reg)
            2'b01: begin
               select_reg <= 1'b0;
               dwell_reg  <= '0;
            end
            2'b10: begin
               select_reg <= 1'b1;
               dwell_reg  <= '0;
            end
            2'b11: begin
               if (dwell_reg == DWELL_LAST) begin
                  select_reg <= ~select_reg;
                  dwell_reg  <= '0;
               end else begin
                  dwell_reg <= dwell_reg + 1'b1;
               end
            end
            default: dwell_reg <= '0;
         endcase
      end
   end

   assign any_alarm = |alarm_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         phase_reg <= '0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg + 1'b1;
      case (state_reg)
         ST_ON: begin
            if (!any_alarm) begin
               state_next = ST_IDLE;
               phase_next = '0;
            end else if (phase_reg == ON_LAST) begin
               state_next = ST_OFF;
               phase_next = '0;
            end
         end
         ST_OFF: begin
            if (!any_alarm) begin
               state_next = ST_IDLE;
               phase_next = '0;
            end else if (phase_reg == OFF_LAST) begin
               state_next = ST_ON;
               phase_next = '0;
            end
         end
         default: begin
            phase_next = '0;
            if (any_alarm)
               state_next = ST_ON;
         end
      endcase
   end

`ifdef BUZZER_SILENCE_EN
   logic [CNT_W-1:0] silence_reg;

   // A freshly latched channel always gets heard, even mid-silence.
   always_ff @(posedge clk) begin
      if (!rst_n)
         silence_reg <= '0;
      else if (|(alarm_next & ~alarm_reg))
         silence_reg <= '0;
      else if (silence && (state_reg != ST_IDLE))
         silence_reg <= CNT_W'(SILENCE_CYC);
      else if (silence_reg != '0)
         silence_reg <= silence_reg - 1'b1;
   end

   always_comb begin
      buzz = (state_reg == ST_ON) && (silence_reg == '0);
   end
`else
   always_comb begin
      buzz = (state_reg == ST_ON);
   end
`endif

   assign alarm  = alarm_reg;
   assign select = select_reg;

endmodule

// File: tb/tb_buzzer_alarm_ctrl.sv
// Directed self-checking bench for buzzer_alarm_ctrl (default build, default parameters).
module tb_buzzer_alarm_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       above_30_0, above_25_0, low_level_0;
   logic       above_30_1, above_25_1, low_level_1;
   logic [1:0] ack;
   logic       select, buzz;
   logic [1:0] alarm;

   int n_cmp = 0;
   int n_err = 0;

   buzzer_alarm_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .above_30_0 (above_30_0),
      .above_25_0 (above_25_0),
      .low_level_0(low_level_0),
      .above_30_1 (above_30_1),
      .above_25_1 (above_25_1),
      .low_level_1(low_level_1),
      .ack        (ack),
      .select     (select),
      .buzz       (buzz),
      .alarm      (alarm)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-14s observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      // Reset held while channel 0 shows an alarm condition
      rst_n = 1'b0;
      ack = 2'b00;
      above_30_0 = 1'b0; above_25_0 = 1'b0; low_level_0 = 1'b0;
      above_30_1 = 1'b0; above_25_1 = 1'b1; low_level_1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step(1);
         chk("rst_alarm", alarm, 2'b00);
         chk("rst_buzz", {1'b0, buzz}, 2'b00);
         chk("rst_select", {1'b0, select}, 2'b00);
      end
      rst_n = 1'b1;
      step(3);
      chk("deb_edge3", alarm, 2'b00);
      step(1);
      chk("deb_edge4", alarm, 2'b01);
      chk("buzz_edge4", {1'b0, buzz}, 2'b00);
      step(1);
      chk("buzz_edge5", {1'b0, buzz}, 2'b01);
      chk("sel_single0", {1'b0, select}, 2'b00);

      // Beep cadence: 8 high / 8 low starting at the first ON cycle
      for (int i = 0; i < 20; i++) begin
         chk("cadence", {1'b0, buzz}, ((i % 16) < 8) ? 2'b01 : 2'b00);
         step(1);
      end
      ack = 2'b01;
      step(1);
      chk("ack_ignored", alarm, 2'b01);
      chk("buzz_on_p5", {1'b0, buzz}, 2'b01);
      ack = 2'b00;
      above_25_0 = 1'b1;
      step(1);
      chk("raw_clr_hold", alarm, 2'b01);
      ack = 2'b01;
      step(1);
      chk("ack_clears", alarm, 2'b00);
      chk("buzz_last_on", {1'b0, buzz}, 2'b01);
      ack = 2'b00;
      step(1);
      chk("fsm_idle", {1'b0, buzz}, 2'b00);
      step(3);
      chk("idle_stays", {1'b0, buzz}, 2'b00);
      chk("sel_hold", {1'b0, select}, 2'b00);

      // Glitch rejection on channel 1
      low_level_1 = 1'b1;
      step(3);
      chk("glitch_3cyc", alarm, 2'b00);
      low_level_1 = 1'b0;
      step(1);
      chk("glitch_alarm", alarm, 2'b00);
      step(2);
      chk("glitch_buzz", {1'b0, buzz}, 2'b00);

      // Dual alarm scheduling
      above_30_0 = 1'b1;
      above_30_1 = 1'b1;
      step(4);
      chk("dual_latch", alarm, 2'b11);
      for (int i = 0; i < 48; i++) begin
         chk("dwell_sel", {1'b0, select}, 2'(((i / 16) % 2)));
         step(1);
      end
      chk("dwell_toggle3", {1'b0, select}, 2'b01);
      above_30_1 = 1'b0;
      step(1);
      chk("dual_hold", alarm, 2'b11);
      ack = 2'b10;
      step(1);
      ack = 2'b00;
      chk("ack_ch1", alarm, 2'b01);
      chk("sel_lag", {1'b0, select}, 2'b01);
      step(1);
      chk("sel_back0", {1'b0, select}, 2'b00);
      step(5);
      chk("sel_stays0", {1'b0, select}, 2'b00);
      chk("alarm_stays", alarm, 2'b01);

      // Ack collides with the debounce-completing edge on channel 1
      above_30_1 = 1'b1;
      step(3);
      chk("coll_pre", alarm, 2'b01);
      ack = 2'b10;
      step(1);
      ack = 2'b00;
      chk("coll_set_wins", alarm, 2'b11);

      // Reset applied mid-beep
      rst_n = 1'b0;
      step(1);
      chk("rst2_alarm", alarm, 2'b00);
      chk("rst2_buzz", {1'b0, buzz}, 2'b00);
      chk("rst2_select", {1'b0, select}, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
